// File: rtl/mem_stage_pipe.sv
// Memory/writeback stage: decodes the EX opcode, resolves writeback and branch redirect,
// issues variable-latency data-memory loads and streams GP pixels over a valid/ready port.
module mem_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 7,
  parameter int OP_W      = 5,
  parameter int ADDR_W    = 20,
  parameter int PIX_W     = 8,
  parameter int PIX_DEPTH = 153600,
  localparam int CNT_W    = (PIX_DEPTH > 1) ? $clog2(PIX_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [REG_W-1:0]  branch_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_result,
  output logic              branch_taken,
  output logic [REG_W-1:0]  branch_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_last,
  output logic              frame_done,
  output logic [CNT_W-1:0]  pix_count,
  output logic              illegal_op
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HOLD_PIX = 2'd2
  } state_e;

  localparam logic [OP_W-1:0]  OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0]  OP_LV  = OP_W'(1);
  localparam logic [OP_W-1:0]  OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0]  OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0]  OP_MUL = OP_W'(4);
  localparam logic [OP_W-1:0]  OP_DIV = OP_W'(5);
  localparam logic [OP_W-1:0]  OP_CP  = OP_W'(6);
  localparam logic [OP_W-1:0]  OP_B   = OP_W'(7);
  localparam logic [OP_W-1:0]  OP_BEQ = OP_W'(8);
  localparam logic [OP_W-1:0]  OP_SLR = OP_W'(9);
  localparam logic [OP_W-1:0]  OP_GP  = OP_W'(10);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_DEPTH - 1);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   wb_result_q, wb_result_d;
  logic                branch_taken_q, branch_taken_d;
  logic [REG_W-1:0]    branch_out_q, branch_out_d;
  logic                dmem_req_q, dmem_req_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic                pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]    pix_data_q, pix_data_d;
  logic                pix_last_q, pix_last_d;
  logic                frame_done_q, frame_done_d;
  logic [CNT_W-1:0]    pix_count_q, pix_count_d;
  logic                illegal_op_q, illegal_op_d;
  logic [REG_W-1:0]    ld_rd_q, ld_rd_d;
  logic [REG_W-1:0]    ld_br_q, ld_br_d;

  // Next-state and next-output decode; strobes and their payloads default to zero.
  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    wb_en_d        = 1'b0;
    wb_rd_d        = '0;
    wb_result_d    = '0;
    branch_taken_d = 1'b0;
    branch_out_d   = '0;
    dmem_req_d     = 1'b0;
    dmem_addr_d    = dmem_addr_q;
    pix_valid_d    = pix_valid_q;
    pix_data_d     = pix_data_q;
    pix_last_d     = pix_last_q;
    frame_done_d   = 1'b0;
    pix_count_d    = pix_count_q;
    illegal_op_d   = 1'b0;
    ld_rd_d        = ld_rd_q;
    ld_br_d        = ld_br_q;
    case (state_q)
      ST_RUN: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          case (opcode)
            OP_NOP: illegal_op_d = 1'b0;
            OP_LV, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SLR: begin
              wb_en_d     = 1'b1;
              wb_rd_d     = rd_in;
              wb_result_d = alu_result;
            end
            OP_CP: begin
              dmem_req_d  = 1'b1;
              dmem_addr_d = alu_result[ADDR_W-1:0];
              ld_rd_d     = rd_in;
              ld_br_d     = branch_in;
              in_ready_d  = 1'b0;
              state_d     = ST_WAIT_MEM;
            end
            OP_B: begin
              branch_taken_d = 1'b1;
              branch_out_d   = branch_in;
            end
            OP_BEQ: begin
              if (alu_result == DATA_W'(1)) begin
                branch_taken_d = 1'b1;
                branch_out_d   = branch_in;
              end else begin
                branch_taken_d = 1'b0;
              end
            end
            OP_GP: begin
              pix_valid_d = 1'b1;
              pix_data_d  = alu_result[PIX_W-1:0];
              pix_last_d  = (pix_count_q == LAST_PIX);
              in_ready_d  = 1'b0;
              state_d     = ST_HOLD_PIX;
            end
            default: illegal_op_d = 1'b1;
          endcase
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT_MEM: begin
        // in_ready stays low through the return cycle so nothing is accepted as we leave.
        in_ready_d = 1'b0;
        if (dmem_rvalid) begin
          wb_en_d        = 1'b1;
          wb_rd_d        = ld_rd_q;
          wb_result_d    = dmem_rdata;
          branch_taken_d = 1'b1;
          branch_out_d   = ld_br_q;
          state_d        = ST_RUN;
        end else begin
          state_d = ST_WAIT_MEM;
        end
      end
      ST_HOLD_PIX: begin
        in_ready_d = 1'b0;
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          state_d     = ST_RUN;
          if (pix_count_q == LAST_PIX) begin
            pix_count_d  = '0;
            frame_done_d = 1'b1;
          end else begin
            pix_count_d = pix_count_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_HOLD_PIX;
        end
      end
      default: begin
        state_d    = ST_RUN;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      in_ready_q     <= 1'b1;
      wb_en_q        <= 1'b0;
      wb_rd_q        <= '0;
      wb_result_q    <= '0;
      branch_taken_q <= 1'b0;
      branch_out_q   <= '0;
      dmem_req_q     <= 1'b0;
      dmem_addr_q    <= '0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      pix_last_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      pix_count_q    <= '0;
      illegal_op_q   <= 1'b0;
      ld_rd_q        <= '0;
      ld_br_q        <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      wb_en_q        <= wb_en_d;
      wb_rd_q        <= wb_rd_d;
      wb_result_q    <= wb_result_d;
      branch_taken_q <= branch_taken_d;
      branch_out_q   <= branch_out_d;
      dmem_req_q     <= dmem_req_d;
      dmem_addr_q    <= dmem_addr_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      pix_last_q     <= pix_last_d;
      frame_done_q   <= frame_done_d;
      pix_count_q    <= pix_count_d;
      illegal_op_q   <= illegal_op_d;
      ld_rd_q        <= ld_rd_d;
      ld_br_q        <= ld_br_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_result    = wb_result_q;
  assign branch_taken = branch_taken_q;
  assign branch_out   = branch_out_q;
  assign dmem_req     = dmem_req_q;
  assign dmem_addr    = dmem_addr_q;
  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign pix_last     = pix_last_q;
  assign frame_done   = frame_done_q;
  assign pix_count    = pix_count_q;
  assign illegal_op   = illegal_op_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe: directed test-plan steps plus randomized
// instructions checked against an opcode-level reference model (small 4-pixel frame).
module tb_mem_stage_pipe;
  localparam int DATA_W = 32;
  localparam int REG_W  = 7;
  localparam int OP_W   = 5;
  localparam int ADDR_W = 20;
  localparam int PIX_W  = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   opcode;
  logic [REG_W-1:0]  rd_in;
  logic [REG_W-1:0]  branch_in;
  logic [DATA_W-1:0] alu_result;
  logic              dmem_req;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_rvalid;
  logic              wb_en;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic              branch_taken;
  logic [REG_W-1:0]  branch_out;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_last;
  logic              frame_done;
  logic [CNT_W-1:0]  pix_count;
  logic              illegal_op;

  int tests_run = 0;
  int fails     = 0;
  int model_cnt = 0;

  mem_stage_pipe #(
    .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .ADDR_W(ADDR_W),
    .PIX_W(PIX_W), .PIX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd_in(rd_in), .branch_in(branch_in), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_result(wb_result),
    .branch_taken(branch_taken), .branch_out(branch_out), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .frame_done(frame_done), .pix_count(pix_count), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Quiet cycle: no strobes, stage ready, pixel counter as modelled.
  task automatic check_idle(input string tag);
    chk({tag, ".wb_en"}, 64'(wb_en), 64'd0);
    chk({tag, ".wb_rd"}, 64'(wb_rd), 64'd0);
    chk({tag, ".wb_result"}, 64'(wb_result), 64'd0);
    chk({tag, ".branch_taken"}, 64'(branch_taken), 64'd0);
    chk({tag, ".branch_out"}, 64'(branch_out), 64'd0);
    chk({tag, ".dmem_req"}, 64'(dmem_req), 64'd0);
    chk({tag, ".pix_valid"}, 64'(pix_valid), 64'd0);
    chk({tag, ".frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, ".illegal_op"}, 64'(illegal_op), 64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".pix_count"}, 64'(pix_count), 64'(model_cnt));
  endtask

  // Issue one instruction and follow it to completion. lat = cycles between the request
  // becoming visible and rvalid (CP), or cycles pix_ready is held low (GP).
  task automatic do_instr(input int op, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] br,
                          input logic [DATA_W-1:0] alu, input int lat, input logic [DATA_W-1:0] rdata);
    bit exp_wb, exp_br, exp_ill, exp_last, exp_done;
    logic [PIX_W-1:0] exp_pix;
    in_valid = 1'b1; opcode = OP_W'(op); rd_in = rd; branch_in = br; alu_result = alu;
    tick();
    in_valid = 1'b0;
    if (op == 6) begin
      chk("cp.dmem_req", 64'(dmem_req), 64'd1);
      chk("cp.dmem_addr", 64'(dmem_addr), 64'(alu % (1 << ADDR_W)));
      chk("cp.in_ready", 64'(in_ready), 64'd0);
      chk("cp.wb_en_early", 64'(wb_en), 64'd0);
      // Offer an ADD while stalled; it must not be taken.
      in_valid = 1'b1; opcode = OP_W'(2); rd_in = rd + 7'd1; alu_result = ~alu;
      for (int k = 0; k < lat; k++) begin
        tick();
        chk("cp.wait.dmem_req", 64'(dmem_req), 64'd0);
        chk("cp.wait.in_ready", 64'(in_ready), 64'd0);
        chk("cp.wait.wb_en", 64'(wb_en), 64'd0);
      end
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      tick();
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      chk("cp.wb_en", 64'(wb_en), 64'd1);
      chk("cp.wb_rd", 64'(wb_rd), 64'(rd));
      chk("cp.wb_result", 64'(wb_result), 64'(rdata));
      chk("cp.branch_taken", 64'(branch_taken), 64'd1);
      chk("cp.branch_out", 64'(branch_out), 64'(br));
      chk("cp.ret.in_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0;
      check_idle("cp.after");
    end else if (op == 10) begin
      exp_pix  = alu[PIX_W-1:0];
      exp_last = (model_cnt == DEPTH - 1);
      chk("gp.pix_valid", 64'(pix_valid), 64'd1);
      chk("gp.pix_data", 64'(pix_data), 64'(exp_pix));
      chk("gp.pix_last", 64'(pix_last), 64'(exp_last));
      chk("gp.in_ready", 64'(in_ready), 64'd0);
      for (int k = 0; k < lat; k++) begin
        pix_ready = 1'b0;
        tick();
        chk("gp.hold.pix_valid", 64'(pix_valid), 64'd1);
        chk("gp.hold.pix_data", 64'(pix_data), 64'(exp_pix));
        chk("gp.hold.pix_last", 64'(pix_last), 64'(exp_last));
        chk("gp.hold.in_ready", 64'(in_ready), 64'd0);
      end
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      exp_done  = (model_cnt == DEPTH - 1);
      model_cnt = (model_cnt + 1) % DEPTH;
      chk("gp.acc.pix_valid", 64'(pix_valid), 64'd0);
      chk("gp.acc.frame_done", 64'(frame_done), 64'(exp_done));
      chk("gp.acc.pix_count", 64'(pix_count), 64'(model_cnt));
      chk("gp.acc.in_ready", 64'(in_ready), 64'd0);
      tick();
      check_idle("gp.after");
    end else begin
      exp_wb  = (op >= 1 && op <= 5) || op == 9;
      exp_br  = (op == 7) || (op == 8 && alu == 32'd1);
      exp_ill = (op > 10);
      chk("op.wb_en", 64'(wb_en), 64'(exp_wb));
      chk("op.wb_rd", 64'(wb_rd), exp_wb ? 64'(rd) : 64'd0);
      chk("op.wb_result", 64'(wb_result), exp_wb ? 64'(alu) : 64'd0);
      chk("op.branch_taken", 64'(branch_taken), 64'(exp_br));
      chk("op.branch_out", 64'(branch_out), exp_br ? 64'(br) : 64'd0);
      chk("op.illegal_op", 64'(illegal_op), 64'(exp_ill));
      chk("op.dmem_req", 64'(dmem_req), 64'd0);
      chk("op.pix_valid", 64'(pix_valid), 64'd0);
      chk("op.in_ready", 64'(in_ready), 64'd1);
      tick();
      check_idle("op.after");
    end
  endtask

  initial begin
    int op;
    logic [DATA_W-1:0] alu;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; rd_in = '0; branch_in = '0;
    alu_result = '0; dmem_rdata = '0; dmem_rvalid = 1'b0; pix_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_idle("reset");
    chk("reset.pix_data", 64'(pix_data), 64'd0);
    chk("reset.pix_last", 64'(pix_last), 64'd0);

    do_instr(2, 7'd5, 7'd0, 32'h1234, 0, 32'h0);
    do_instr(8, 7'd0, 7'h2A, 32'd1, 0, 32'h0);
    do_instr(8, 7'd0, 7'h2A, 32'd0, 0, 32'h0);
    do_instr(6, 7'd3, 7'h11, 32'h00100, 4, 32'hDEADBEEF);

    // One full frame of four pixels with assorted backpressure.
    do_instr(10, 7'd0, 7'd0, 32'hAB55, 3, 32'h0);
    do_instr(10, 7'd0, 7'd0, 32'h0012, 0, 32'h0);
    do_instr(10, 7'd0, 7'd0, 32'h00C3, 1, 32'h0);
    do_instr(10, 7'd0, 7'd0, 32'h00FF, 2, 32'h0);

    do_instr(15, 7'd9, 7'd4, 32'h5, 0, 32'h0);

    for (int i = 0; i < 80; i++) begin
      op  = int'($urandom_range(0, 31));
      alu = $urandom;
      if (op == 8 && $urandom_range(0, 2) != 0) alu = 32'($urandom_range(0, 1));
      do_instr(op, 7'($urandom), 7'($urandom), alu, int'($urandom_range(0, 5)), $urandom);
    end

    // Reset while a load is outstanding; the late rvalid must be ignored.
    in_valid = 1'b1; opcode = 5'd6; rd_in = 7'd12; branch_in = 7'd33; alu_result = 32'h000ABCDE;
    tick();
    in_valid = 1'b0;
    chk("rstmid.dmem_req", 64'(dmem_req), 64'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 0;
    check_idle("rstmid.reset");
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    check_idle("rstmid.late_rvalid");
    tick();
    check_idle("rstmid.after");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
